// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam int BYTE_EN_WIDTH = 4;
  localparam logic [BYTE_EN_WIDTH-1:0] FETCH_BYTE_EN = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter for a single-port fixed-latency memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_LATENCY   = 2,
  parameter int MAX_D_STREAK  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IReq,
  input  logic [ADDRESS_WIDTH-1:0] IAddr,
  input  logic                     IKill,
  output logic [DATA_WIDTH-1:0]    IRData,
  output logic                     IValid,
  input  logic                     DReq,
  input  logic                     DWE,
  input  logic [BYTE_EN_WIDTH-1:0] DByteEn,
  input  logic [ADDRESS_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0]    DWData,
  output logic [DATA_WIDTH-1:0]    DRData,
  output logic                     DValid,
  output logic                     StallF,
  output logic                     StallM,
  output logic                     MemReq,
  output logic                     MemWE,
  output logic [BYTE_EN_WIDTH-1:0] MemByteEn,
  output logic [ADDRESS_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0]    MemWData,
  input  logic [DATA_WIDTH-1:0]    MemRData
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;

  logic grant_i;
  logic i_done, d_done;

  // Data port wins unless fetch has been passed over MAX_D_STREAK times in a row.
  assign grant_i = IReq & ~IKill & (~DReq | (streak_q == STREAK_MAX));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    streak_d  = streak_q;
    kill_d    = kill_q;
    MemReq    = 1'b0;
    MemWE     = 1'b0;
    MemByteEn = '0;
    MemAddr   = '0;
    MemWData  = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (grant_i) begin
          MemReq    = 1'b1;
          MemByteEn = FETCH_BYTE_EN;
          MemAddr   = IAddr;
          cnt_d     = CNT_LOAD;
          state_d   = BUSY_I;
          streak_d  = '0;
        end else if (DReq) begin
          MemReq    = 1'b1;
          MemWE     = DWE;
          MemByteEn = DByteEn;
          MemAddr   = DAddr;
          MemWData  = DWData;
          cnt_d     = CNT_LOAD;
          state_d   = BUSY_D;
          if (IReq && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end
      end
      BUSY_I: begin
        kill_d = kill_q | IKill;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          i_done  = 1'b1;
          state_d = IDLE;
          kill_d  = 1'b0;
        end
      end
      BUSY_D: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          d_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!IReq) streak_d = '0;

    // Reset overrides every combinational strobe as well as the registered state.
    if (!RST) begin
      MemReq    = 1'b0;
      MemWE     = 1'b0;
      MemByteEn = '0;
      MemAddr   = '0;
      MemWData  = '0;
      i_done    = 1'b0;
      d_done    = 1'b0;
    end
  end

  // A kill arriving in the completion cycle itself also discards the fetch.
  assign IValid = i_done & ~kill_q & ~IKill;
  assign DValid = d_done;

  assign irdata_d = IValid ? MemRData : irdata_q;
  assign drdata_d = DValid ? MemRData : drdata_q;
  assign IRData   = irdata_d;
  assign DRData   = drdata_d;

  assign StallF = IReq & ~IValid & ~IKill;
  assign StallM = DReq & ~DValid;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      streak_q <= '0;
      kill_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      kill_q   <= kill_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IReq, IKill, IValid;
  logic [AW-1:0] IAddr;
  logic [DW-1:0] IRData;
  logic          DReq, DWE, DValid;
  logic [3:0]    DByteEn;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWData, DRData;
  logic          StallF, StallM;
  logic          MemReq, MemWE;
  logic [3:0]    MemByteEn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData, MemRData;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_LATENCY(LAT), .MAX_D_STREAK(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .IReq(IReq), .IAddr(IAddr), .IKill(IKill), .IRData(IRData), .IValid(IValid),
    .DReq(DReq), .DWE(DWE), .DByteEn(DByteEn), .DAddr(DAddr), .DWData(DWData),
    .DRData(DRData), .DValid(DValid), .StallF(StallF), .StallM(StallM),
    .MemReq(MemReq), .MemWE(MemWE), .MemByteEn(MemByteEn), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData)
  );

  // Memory model: read data appears exactly LAT cycles after the issue cycle, garbage otherwise.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'h00500093;
    return a ^ 32'hA5A50000;
  endfunction

  logic [DW-1:0] rd_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'hBAD0BAD0;
  always @(posedge CLK) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (MemReq && !MemWE) ? mem_word(MemAddr) : 32'hBAD0BAD0;
  end
  assign MemRData = rd_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle: inputs are driven 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  logic [AW-1:0] daddr;

  initial begin
    RST = 1'b0; IReq = 0; IAddr = '0; IKill = 0;
    DReq = 0; DWE = 0; DByteEn = '0; DAddr = '0; DWData = '0;
    next_cycle(); next_cycle();
    settle();
    check("rst_memreq", MemReq, 0);
    check("rst_ivalid", IValid, 0);
    check("rst_dvalid", DValid, 0);
    check("rst_irdata", IRData, 0);
    check("rst_drdata", DRData, 0);
    next_cycle();
    RST = 1'b1;

    // Fetch only
    IReq = 1; IAddr = 32'h10; settle();
    check("f_c0_memreq", MemReq, 1);
    check("f_c0_addr", MemAddr, 32'h10);
    check("f_c0_we", MemWE, 0);
    check("f_c0_be", MemByteEn, 4'b1111);
    check("f_c0_stallf", StallF, 1);
    next_cycle(); settle();
    check("f_c1_memreq", MemReq, 0);
    check("f_c1_ivalid", IValid, 0);
    check("f_c1_stallf", StallF, 1);
    next_cycle(); settle();
    check("f_c2_ivalid", IValid, 1);
    check("f_c2_irdata", IRData, 32'h00500093);
    check("f_c2_stallf", StallF, 0);
    next_cycle(); IReq = 0; settle();
    check("f_c3_ivalid", IValid, 0);
    check("f_c3_irdata_hold", IRData, 32'h00500093);

    // Simultaneous requests: data first
    next_cycle();
    IReq = 1; IAddr = 32'h20; DReq = 1; DWE = 0; DByteEn = 4'b1111; DAddr = 32'h100; settle();
    check("s_c0_memreq", MemReq, 1);
    check("s_c0_addr", MemAddr, 32'h100);
    check("s_c0_stallf", StallF, 1);
    check("s_c0_stallm", StallM, 1);
    next_cycle(); settle();
    check("s_c1_stallf", StallF, 1);
    next_cycle(); settle();
    check("s_c2_dvalid", DValid, 1);
    check("s_c2_drdata", DRData, 32'hA5A50100);
    check("s_c2_stallm", StallM, 0);
    check("s_c2_stallf", StallF, 1);
    next_cycle(); DReq = 0; settle();
    check("s_c3_memreq", MemReq, 1);
    check("s_c3_addr", MemAddr, 32'h20);
    check("s_c3_be", MemByteEn, 4'b1111);
    check("s_c3_stallf", StallF, 1);
    next_cycle(); settle();
    check("s_c4_stallf", StallF, 1);
    next_cycle(); settle();
    check("s_c5_ivalid", IValid, 1);
    check("s_c5_irdata", IRData, 32'hA5A50020);
    check("s_c5_stallf", StallF, 0);
    next_cycle(); IReq = 0;

    // Starvation guard: four data grants, then fetch at cycle 12
    next_cycle();
    daddr = 32'h200;
    IReq = 1; IAddr = 32'h30; DReq = 1; DWE = 0; DAddr = daddr;
    for (int c = 0; c < 15; c++) begin
      settle();
      if (c % 3 == 0) begin
        check($sformatf("st_c%0d_memreq", c), MemReq, 1);
        check($sformatf("st_c%0d_addr", c), MemAddr, (c == 12) ? 32'h30 : daddr);
      end else begin
        check($sformatf("st_c%0d_memreq", c), MemReq, 0);
      end
      if (c % 3 == 2 && c < 12) begin
        check($sformatf("st_c%0d_dvalid", c), DValid, 1);
        check($sformatf("st_c%0d_drdata", c), DRData, daddr ^ 32'hA5A50000);
      end
      if (c == 14) begin
        check("st_c14_ivalid", IValid, 1);
        check("st_c14_irdata", IRData, 32'hA5A50030);
      end
      next_cycle();
      if (c % 3 == 2 && c < 12) begin
        daddr = daddr + 32'h4;
        DAddr = daddr;
      end
    end
    // Streak cleared by the fetch grant, so data wins again over a new fetch.
    IAddr = 32'h34; settle();
    check("st_c15_memreq", MemReq, 1);
    check("st_c15_addr", MemAddr, daddr);
    next_cycle(); IReq = 0;
    next_cycle();
    next_cycle(); DReq = 0;

    // Kill: blocked in IDLE, then discarded in flight
    next_cycle();
    IReq = 1; IAddr = 32'h10; IKill = 1; settle();
    check("k_idle_memreq", MemReq, 0);
    check("k_idle_stallf", StallF, 0);
    next_cycle(); IKill = 0; settle();
    check("k_c0_memreq", MemReq, 1);
    next_cycle(); IKill = 1; settle();
    check("k_c1_stallf", StallF, 0);
    next_cycle(); IKill = 0; IReq = 0; settle();
    check("k_c2_ivalid", IValid, 0);
    check("k_c2_irdata_hold", IRData, 32'hA5A50030);
    next_cycle(); IReq = 1; IAddr = 32'h40; settle();
    check("k_c3_memreq", MemReq, 1);
    check("k_c3_addr", MemAddr, 32'h40);
    next_cycle(); next_cycle(); settle();
    check("k_c5_ivalid", IValid, 1);
    check("k_c5_irdata", IRData, 32'hA5A50040);
    next_cycle(); IReq = 0;

    // Store
    next_cycle();
    DReq = 1; DWE = 1; DByteEn = 4'b0011; DAddr = 32'h204; DWData = 32'hDEADBEEF; settle();
    check("w_c0_memreq", MemReq, 1);
    check("w_c0_we", MemWE, 1);
    check("w_c0_be", MemByteEn, 4'b0011);
    check("w_c0_addr", MemAddr, 32'h204);
    check("w_c0_wdata", MemWData, 32'hDEADBEEF);
    next_cycle(); settle();
    check("w_c1_dvalid", DValid, 0);
    check("w_c1_we", MemWE, 0);
    next_cycle(); settle();
    check("w_c2_dvalid", DValid, 1);
    next_cycle(); DReq = 0; DWE = 0; settle();
    check("w_c3_dvalid", DValid, 0);

    // Reset during a data access, then re-issue
    next_cycle();
    DReq = 1; DWE = 0; DByteEn = 4'b1111; DAddr = 32'h300; settle();
    check("r_c0_memreq", MemReq, 1);
    next_cycle(); RST = 0; settle();
    next_cycle(); settle();
    check("r_c2_dvalid", DValid, 0);
    check("r_c2_memreq", MemReq, 0);
    next_cycle(); RST = 1; settle();
    check("r_c3_memreq", MemReq, 1);
    check("r_c3_addr", MemAddr, 32'h300);
    next_cycle(); settle();
    check("r_c4_dvalid", DValid, 0);
    next_cycle(); settle();
    check("r_c5_dvalid", DValid, 1);
    check("r_c5_drdata", DRData, 32'hA5A50300);
    next_cycle(); DReq = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
